// File: rtl/ofb_stream_xcrypt.sv
// OFB/CTR keystream engine: prefetches cipher-core output blocks into a small
// FIFO and XORs one keystream block onto each streamed input block.
module ofb_stream_xcrypt #(
    parameter int BLK_W    = 128,
    parameter int KS_DEPTH = 4,
    parameter int CTR_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_i,
    input  logic             mode_ctr_i,
    input  logic [BLK_W-1:0] iv_i,
    output logic             core_start_o,
    output logic [BLK_W-1:0] core_blk_o,
    input  logic             core_done_i,
    input  logic [BLK_W-1:0] core_res_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [BLK_W-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [BLK_W-1:0] out_data_o,
    output logic             busy_o,
    output logic [31:0]      blk_cnt_o,
    output logic [1:0]       state_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // a source holds valid and data stable until it is accepted.
    localparam int PTR_W = $clog2(KS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [BLK_W-1:0] CTR_MASK =
        (CTR_W >= BLK_W) ? {BLK_W{1'b1}} : ((BLK_W'(1) << CTR_W) - BLK_W'(1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               drop_q, drop_d;
    logic               mode_q, mode_d;
    logic               busy_q, busy_d;
    logic [BLK_W-1:0]   fb_q, fb_d;
    logic [CNT_W-1:0]   ks_cnt_q, ks_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [BLK_W-1:0]   out_data_q, out_data_d;
    logic [31:0]        blk_cnt_q, blk_cnt_d;
    logic [BLK_W-1:0]   mem_q [KS_DEPTH];

    logic done_acc, push, in_hs, out_hs, ks_full;

    assign ks_full    = (ks_cnt_q == CNT_W'(KS_DEPTH));
    assign done_acc   = core_done_i && (state_q == S_WAIT);
    assign push       = done_acc && !drop_q && !ld_i;
    assign in_ready_o = (ks_cnt_q != '0) && (!out_valid_q || out_ready_i) && !ld_i;
    assign in_hs      = in_valid_i && in_ready_o;
    assign out_hs     = out_valid_q && out_ready_i && !ld_i;

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        core_start_o = 1'b0;
        case (state_q)
            S_ISSUE: begin
                if (!ld_i && !ks_full) begin
                    core_start_o = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_acc) begin
                    state_d = S_ISSUE;
                    drop_d  = 1'b0;
                end
            end
            default: ;
        endcase
        // A reload while the core is busy must swallow that request's result.
        if (ld_i) begin
            if (state_q == S_WAIT && !done_acc) begin
                state_d = S_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = S_ISSUE;
                drop_d  = 1'b0;
            end
        end
    end

    always_comb begin
        fb_d        = fb_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        ks_cnt_d    = ks_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        blk_cnt_d   = blk_cnt_q;
        if (ld_i) begin
            fb_d        = iv_i;
            mode_d      = mode_ctr_i;
            busy_d      = 1'b1;
            ks_cnt_d    = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            blk_cnt_d   = '0;
        end else begin
            // Counter field wraps on its own; bits above CTR_W never change.
            if (core_start_o && mode_q)
                fb_d = (fb_q & ~CTR_MASK) | ((fb_q + BLK_W'(1)) & CTR_MASK);
            else if (done_acc && !drop_q && !mode_q)
                fb_d = core_res_i;
            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (in_hs)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            ks_cnt_d = ks_cnt_q + CNT_W'(push) - CNT_W'(in_hs);
            if (in_hs) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data_i ^ mem_q[rd_ptr_q];
            end else if (out_hs) begin
                out_valid_d = 1'b0;
            end
            if (out_hs)
                blk_cnt_d = blk_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            drop_q      <= 1'b0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            fb_q        <= '0;
            ks_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            fb_q        <= fb_d;
            ks_cnt_q    <= ks_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= core_res_i;
    end

    assign core_blk_o  = fb_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy_q;
    assign blk_cnt_o   = blk_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_ofb_stream_xcrypt.sv
// Bench for ofb_stream_xcrypt: inverting cipher-core model plus a keystream
// reference computed directly from the IV, mode and block index.
module tb_ofb_stream_xcrypt;
    localparam int BLK_W    = 128;
    localparam int KS_DEPTH = 4;
    localparam int CTR_W    = 32;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1, ld = 1'b0, mode_ctr = 1'b0;
    logic [BLK_W-1:0] iv = '0;
    logic             core_start, core_done = 1'b0;
    logic [BLK_W-1:0] core_blk, core_res = '0;
    logic             in_valid = 1'b0, in_ready;
    logic [BLK_W-1:0] in_data = '0;
    logic             out_valid, out_ready = 1'b0;
    logic [BLK_W-1:0] out_data;
    logic             busy;
    logic [31:0]      blk_cnt;
    logic [1:0]       state;

    ofb_stream_xcrypt #(.BLK_W(BLK_W), .KS_DEPTH(KS_DEPTH), .CTR_W(CTR_W)) dut (
        .clk_i(clk), .rst_i(rst), .ld_i(ld), .mode_ctr_i(mode_ctr), .iv_i(iv),
        .core_start_o(core_start), .core_blk_o(core_blk),
        .core_done_i(core_done), .core_res_i(core_res),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .busy_o(busy), .blk_cnt_o(blk_cnt), .state_o(state)
    );

    // ---------------- checking ----------------
    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [BLK_W-1:0] core_fn(input logic [BLK_W-1:0] x);
        return ~x;
    endfunction

    // Block fed to the core for keystream index n.
    function automatic logic [BLK_W-1:0] in_blk(input logic [BLK_W-1:0] v, input logic ctr, input int n);
        logic [BLK_W-1:0] b = v;
        if (ctr) b[CTR_W-1:0] = v[CTR_W-1:0] + CTR_W'(n);
        else for (int i = 0; i < n; i++) b = core_fn(b);
        return b;
    endfunction

    logic             m_loaded = 0, m_busy = 0, m_mode = 0, m_out = 0;
    int               m_out_epoch = 0, epoch = 0;
    logic [BLK_W-1:0] m_iv = '0, last_out = '0;
    int               avail = 0, n_issued = 0, n_consumed = 0;
    logic [31:0]      m_cnt = '0;
    logic [BLK_W-1:0] exp_q[$];

    // cipher-core environment and logs of DUT traffic
    int               due_q[$];
    logic [BLK_W-1:0] res_q[$];
    int               lat = 2, cyc = 0;
    logic [BLK_W-1:0] out_log[$], blk_log[$], in_log[$];

    // ---------------- driver ----------------
    task automatic cycle(input logic r, input logic l, input logic m, input logic [BLK_W-1:0] v,
                         input logic ivld, input logic [BLK_W-1:0] d, input logic ordy);
        logic exp_start, exp_ir, exp_ov, in_hs, out_hs;
        logic [BLK_W-1:0] exp_od;
        @(negedge clk);
        rst = r; ld = l; mode_ctr = m; iv = v;
        in_valid = ivld; in_data = d; out_ready = ordy;
        core_done = 1'b0; core_res = '0;
        if (due_q.size() != 0 && due_q[0] == cyc) begin
            core_done = 1'b1;
            core_res  = res_q[0];
            void'(due_q.pop_front());
            void'(res_q.pop_front());
        end
        #1;
        exp_ov    = (exp_q.size() != 0);
        exp_od    = exp_ov ? exp_q[0] : last_out;
        exp_start = m_loaded && !m_out && (avail < KS_DEPTH) && !l;
        exp_ir    = (avail != 0) && (!exp_ov || ordy) && !l;
        check("core_start", core_start, exp_start);
        if (exp_start) check("core_blk", core_blk, in_blk(m_iv, m_mode, n_issued));
        else if (!m_loaded) check("core_blk_idle", core_blk, '0);
        check("in_ready", in_ready, exp_ir);
        check("out_valid", out_valid, exp_ov);
        check("out_data", out_data, exp_od);
        check("busy", busy, m_busy);
        check("blk_cnt", blk_cnt, m_cnt);

        if (core_start) begin
            due_q.push_back(cyc + lat);
            res_q.push_back(core_fn(core_blk));
            blk_log.push_back(core_blk);
        end
        if (in_valid && in_ready) in_log.push_back(d);
        if (out_valid && out_ready) out_log.push_back(out_data);

        in_hs  = ivld && exp_ir;
        out_hs = exp_ov && ordy;
        if (r) begin
            m_loaded = 0; m_busy = 0; m_out = 0; avail = 0;
            exp_q.delete(); last_out = '0; m_cnt = '0; epoch++;
        end else begin
            if (core_done && m_out) begin
                m_out = 0;
                if (m_out_epoch == epoch && !l) avail++;
            end
            if (l) begin
                epoch++; m_loaded = 1; m_busy = 1; m_mode = m; m_iv = v;
                avail = 0; exp_q.delete(); last_out = '0; m_cnt = '0;
                n_issued = 0; n_consumed = 0;
            end else begin
                if (exp_start) begin m_out = 1; m_out_epoch = epoch; n_issued++; end
                if (out_hs) begin last_out = exp_q.pop_front(); m_cnt++; end
                if (in_hs) begin
                    exp_q.push_back(d ^ core_fn(in_blk(m_iv, m_mode, n_consumed)));
                    n_consumed++;
                    avail--;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, '0, ordy);
    endtask

    task automatic drain_core();
        for (int k = 0; k < 20 && due_q.size() != 0; k++) idle(1, 1);
        check("core_drain", due_q.size(), 0);
    endtask

    function automatic logic [BLK_W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    logic [BLK_W-1:0] d0, v0;
    initial begin
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0, 0, '0, 0);
        idle(2, 0);

        // OFB, iv = 0, three zero blocks
        out_log.delete(); blk_log.delete();
        cycle(0, 1, 0, '0, 0, '0, 1);
        for (int i = 0; i < 60 && out_log.size() < 3; i++) cycle(0, 0, 0, '0, n_consumed < 3, '0, 1);
        idle(1, 1);
        check("ofb_outputs", out_log.size(), 3);
        if (out_log.size() >= 3) begin
            check("ofb_blk0", out_log[0], {BLK_W{1'b1}});
            check("ofb_blk1", out_log[1], '0);
            check("ofb_blk2", out_log[2], {BLK_W{1'b1}});
        end
        check("ofb_cnt", blk_cnt, 3);

        // CTR, counter field wraps with no carry into bit CTR_W
        out_log.delete(); blk_log.delete();
        cycle(0, 1, 1, {96'h0, 32'hFFFF_FFFF}, 0, '0, 1);
        for (int i = 0; i < 60 && out_log.size() < 2; i++) cycle(0, 0, 0, '0, n_consumed < 2, '0, 1);
        check("ctr_outputs", out_log.size(), 2);
        if (out_log.size() >= 2 && blk_log.size() >= 2) begin
            check("ctr_req0", blk_log[0], {96'h0, 32'hFFFF_FFFF});
            check("ctr_req1", blk_log[1], '0);
            check("ctr_out0", out_log[0], {{96{1'b1}}, 32'h0});
            check("ctr_out1", out_log[1], {BLK_W{1'b1}});
        end

        // Backpressure: one accept, FIFO refills, core idles, then drain in order
        in_log.delete(); out_log.delete(); blk_log.delete();
        d0 = rnd();
        cycle(0, 1, 0, rnd(), 0, '0, 0);
        for (int i = 0; i < 40; i++) cycle(0, 0, 0, '0, 1, d0, 0);
        check("bp_accepted", in_log.size(), 1);
        check("bp_requests", blk_log.size(), KS_DEPTH + 1);
        for (int i = 0; i < 40; i++) cycle(0, 0, 0, '0, in_log.size() < KS_DEPTH + 1, rnd(), 1);
        check("bp_drained", out_log.size(), KS_DEPTH + 1);

        // Reload while a request is outstanding: stale result must be dropped
        lat = 2;
        blk_log.delete();
        cycle(0, 1, 0, rnd(), 0, '0, 1);
        for (int i = 0; i < 20 && blk_log.size() == 0; i++) idle(1, 1);
        in_log.delete(); out_log.delete();
        v0 = {{(BLK_W-1){1'b0}}, 1'b1};
        cycle(0, 1, 0, v0, 0, '0, 1);
        for (int i = 0; i < 40 && out_log.size() < 3; i++) cycle(0, 0, 0, '0, 1, rnd(), 1);
        check("stale_outputs", out_log.size() >= 1, 1);
        if (out_log.size() >= 1 && in_log.size() >= 1) check("stale_first", out_log[0], ~v0 ^ in_log[0]);
        idle(2, 1);
        check("stale_cnt", blk_cnt, out_log.size());

        // ld and input handshake in the same cycle
        cycle(0, 1, 0, rnd(), 0, '0, 1);
        idle(15, 1);
        cycle(0, 1, 1, rnd(), 1, rnd(), 1);
        check("ld_in_ready", in_ready, 0);
        idle(1, 1);
        check("ld_out_valid", out_valid, 0);

        // Reset mid-stream with a request outstanding
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, '0, 1, rnd(), 1);
        blk_log.delete();
        for (int i = 0; i < 20 && blk_log.size() == 0; i++) cycle(0, 0, 0, '0, 1, rnd(), 1);
        cycle(1, 0, 0, '0, 1, rnd(), 1);
        idle(1, 1);
        check("rst_core_start", core_start, 0);
        check("rst_core_blk", core_blk, '0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, '0);
        check("rst_busy", busy, 0);
        check("rst_blk_cnt", blk_cnt, 0);
        drain_core();
        idle(3, 1);

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            lat = $urandom_range(1, 4);
            if ($urandom_range(0, 599) == 0) begin
                cycle(1, 0, 0, '0, 0, '0, 1);
                drain_core();
            end else if (!m_loaded || $urandom_range(0, 99) == 0) begin
                cycle(0, 1, 1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)), rnd(),
                      1'($urandom_range(0, 1)));
            end else begin
                cycle(0, 0, 0, '0, $urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 3) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
